// File: rtl/cache_bus_arbiter_if.sv
// Sram-like request/response channel shared by the cache ports and the bridge port.
// The master side issues requests; the slave side answers with addr_ok/data_ok/rdata.
interface cache_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter serializing the instruction and data cache miss ports
// onto one sram-like bus port, with a single transaction in flight.
module cache_bus_arbiter (
  input  logic                       clk,
  input  logic                       rst,
  cache_bus_arbiter_if.slave         inst,
  cache_bus_arbiter_if.slave         data,
  cache_bus_arbiter_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_grant_reg, last_grant_next;
  logic        wr_reg, wr_next;
  logic [1:0]  size_reg, size_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic        grant_data;
  logic        busy;
  logic        in_addr;
  logic        in_data;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    grant_data = data.req && (!inst.req || !last_grant_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      wr_reg         <= wr_next;
      size_reg       <= size_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    wr_next         = wr_reg;
    size_next       = size_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (inst.req || data.req) begin
          state_next      = ADDR;
          owner_next      = grant_data;
          last_grant_next = grant_data;
          wr_next         = grant_data ? data.wr    : inst.wr;
          size_next       = grant_data ? data.size  : inst.size;
          addr_next       = grant_data ? data.addr  : inst.addr;
          wdata_next      = grant_data ? data.wdata : inst.wdata;
        end
      end
      ADDR: begin
        if (bus.addr_ok) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.data_ok) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign in_addr = (state_reg == ADDR);
  assign in_data = (state_reg == DATA);

  // Latched fields stay registered after a transaction; gate them so IDLE shows zeros.
  assign bus.req   = in_addr;
  assign bus.wr    = busy && wr_reg;
  assign bus.size  = busy ? size_reg  : 2'd0;
  assign bus.addr  = busy ? addr_reg  : 32'd0;
  assign bus.wdata = busy ? wdata_reg : 32'd0;

  assign inst.addr_ok = in_addr && !owner_reg && bus.addr_ok;
  assign data.addr_ok = in_addr &&  owner_reg && bus.addr_ok;
  assign inst.data_ok = in_data && !owner_reg && bus.data_ok;
  assign data.data_ok = in_data &&  owner_reg && bus.data_ok;

  assign inst.rdata = bus.rdata;
  assign data.rdata = bus.rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: stimulus pushes expected bus transactions
// and read responses into queues, a negedge monitor pops and compares them.
module tb_cache_bus_arbiter;

  logic clk;
  logic rst;

  cache_bus_arbiter_if inst_if ();
  cache_bus_arbiter_if data_if ();
  cache_bus_arbiter_if bus_if ();

  cache_bus_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if.slave),
    .data (data_if.slave),
    .bus  (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  bus_exp_t be;
  rsp_exp_t re;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Monitor: compares every bus handshake and every data_ok against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.req && bus_if.addr_ok) begin
        if (bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: handshake at addr 0x%08h, required none", bus_if.addr);
        end else begin
          be = bus_q.pop_front();
          $display("[TB] bus txn port=%s wr=%0d size=%0d addr=0x%08h wdata=0x%08h",
                   be.who ? "data" : "inst", bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata);
          check1("bus_wr", bus_if.wr, be.wr);
          check("bus_size", {30'd0, bus_if.size}, {30'd0, be.size});
          check("bus_addr", bus_if.addr, be.addr);
          check("bus_wdata", bus_if.wdata, be.wdata);
          check1("inst_addr_ok", inst_if.addr_ok, !be.who);
          check1("data_addr_ok", data_if.addr_ok, be.who);
        end
      end else if (inst_if.addr_ok || data_if.addr_ok) begin
        tests++;
        fails++;
        $display("FAIL stray_addr_ok: inst=%b data=%b, required 0/0", inst_if.addr_ok, data_if.addr_ok);
      end
      if (inst_if.data_ok || data_if.data_ok) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: inst_data_ok=%b data_data_ok=%b, required 0/0",
                   inst_if.data_ok, data_if.data_ok);
        end else begin
          re = rsp_q.pop_front();
          $display("[TB] rsp port=%s rdata=0x%08h", re.who ? "data" : "inst",
                   re.who ? data_if.rdata : inst_if.rdata);
          check1("inst_data_ok", inst_if.data_ok, !re.who);
          check1("data_data_ok", data_if.data_ok, re.who);
          check("rsp_rdata", re.who ? data_if.rdata : inst_if.rdata, re.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_req();
    int n = 0;
    while (!bus_if.req && n < 20) begin
      step();
      n++;
    end
    if (!bus_if.req) begin
      tests++;
      fails++;
      $display("FAIL bus_req_timeout: bus_req=0 after 20 cycles, required 1");
    end
  endtask

  task automatic set_inst(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    inst_if.req = req; inst_if.wr = wr; inst_if.size = size;
    inst_if.addr = addr; inst_if.wdata = wdata;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    data_if.req = req; data_if.wr = wr; data_if.size = size;
    data_if.addr = addr; data_if.wdata = wdata;
  endtask

  task automatic push_bus(input logic who, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus_exp_t e;
    e.who = who; e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  task automatic push_rsp(input logic who, input logic [31:0] rdata);
    rsp_exp_t e;
    e.who = who; e.rdata = rdata;
    rsp_q.push_back(e);
  endtask

  // Bridge model: accept the address, wait gap cycles, return rdata.
  task automatic serve(input logic [31:0] rdata, input bit drop_inst, input bit drop_data, input int gap);
    wait_bus_req();
    bus_if.addr_ok = 1'b1;
    step();
    bus_if.addr_ok = 1'b0;
    if (drop_inst) inst_if.req = 1'b0;
    if (drop_data) data_if.req = 1'b0;
    repeat (gap) step();
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = rdata;
    step();
    bus_if.data_ok = 1'b0;
    bus_if.rdata   = 32'h0;
  endtask

  localparam logic [31:0] IADDR = 32'h1FC0_0100;
  localparam logic [31:0] DADDR = 32'h8000_2000;

  initial begin
    rst = 1'b1;
    set_inst(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    set_data(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    bus_if.rdata = 32'h0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
    repeat (3) step();

    // Reset outputs
    @(negedge clk);
    check1("rst_bus_req", bus_if.req, 1'b0);
    check1("rst_bus_wr", bus_if.wr, 1'b0);
    check("rst_bus_size", {30'd0, bus_if.size}, 32'd0);
    check("rst_bus_addr", bus_if.addr, 32'd0);
    check("rst_bus_wdata", bus_if.wdata, 32'd0);
    check1("rst_inst_ok", inst_if.addr_ok | inst_if.data_ok, 1'b0);
    check1("rst_data_ok", data_if.addr_ok | data_if.data_ok, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Single instruction read
    set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    push_bus(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    push_rsp(1'b0, 32'h3C08_0001);
    @(negedge clk);
    check1("lat_idle_bus_req", bus_if.req, 1'b0);
    step();
    check1("lat_bus_req", bus_if.req, 1'b1);
    check("lat_bus_addr", bus_if.addr, 32'hBFC0_0000);
    serve(32'h3C08_0001, 1'b1, 1'b0, 1);
    step();

    // Simultaneous requests right after reset: data first, inst two cycles after data_ok
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_inst(1'b1, 1'b0, 2'd2, IADDR, 32'h0);
    set_data(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    push_bus(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    push_rsp(1'b1, 32'h1111_0001);
    push_bus(1'b0, 1'b0, 2'd2, IADDR, 32'h0);
    push_rsp(1'b0, 32'h1111_0002);
    serve(32'h1111_0001, 1'b0, 1'b1, 0);
    check1("b2b_gap_bus_req", bus_if.req, 1'b0);
    step();
    check1("b2b_rise_bus_req", bus_if.req, 1'b1);
    serve(32'h1111_0002, 1'b1, 1'b0, 0);
    step();

    // Fairness: both held for six transactions, grants alternate D,I,D,I,D,I
    set_inst(1'b1, 1'b0, 2'd2, IADDR, 32'h0);
    set_data(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_bus(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
      else            push_bus(1'b0, 1'b0, 2'd2, IADDR, 32'h0);
      push_rsp((i % 2 == 0) ? 1'b1 : 1'b0, 32'hA000_0000 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      serve(32'hA000_0000 + 32'(i), i == 5, i == 4, i % 3);
    end
    step();

    // Data write, fields changed after acceptance must not reach the bus
    set_data(1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF);
    push_bus(1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF);
    push_rsp(1'b1, 32'h0000_0000);
    wait_bus_req();
    bus_if.addr_ok = 1'b1;
    step();
    bus_if.addr_ok = 1'b0;
    set_data(1'b0, 1'b0, 2'd1, 32'hFFFF_0000, 32'h0);
    @(negedge clk);
    check("hold_bus_addr", bus_if.addr, 32'h8000_1000);
    check("hold_bus_wdata", bus_if.wdata, 32'hDEAD_BEEF);
    check1("hold_bus_wr", bus_if.wr, 1'b1);
    step();
    bus_if.data_ok = 1'b1;
    step();
    bus_if.data_ok = 1'b0;
    step();

    // Spurious handshakes in IDLE and ADDR
    bus_if.data_ok = 1'b1;
    bus_if.addr_ok = 1'b1;
    @(negedge clk);
    check1("spur_idle_inst_data_ok", inst_if.data_ok, 1'b0);
    check1("spur_idle_data_data_ok", data_if.data_ok, 1'b0);
    step();
    bus_if.data_ok = 1'b0;
    bus_if.addr_ok = 1'b0;
    check1("spur_idle_state", bus_if.req, 1'b0);
    set_inst(1'b1, 1'b0, 2'd0, 32'h0000_4000, 32'h0);
    push_bus(1'b0, 1'b0, 2'd0, 32'h0000_4000, 32'h0);
    push_rsp(1'b0, 32'h55AA_55AA);
    wait_bus_req();
    bus_if.data_ok = 1'b1;
    @(negedge clk);
    check1("spur_addr_inst_data_ok", inst_if.data_ok, 1'b0);
    step();
    bus_if.data_ok = 1'b0;
    check1("spur_addr_state", bus_if.req, 1'b1);
    serve(32'h55AA_55AA, 1'b1, 1'b0, 0);
    step();

    // Reset while in DATA abandons the transaction
    set_data(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    push_bus(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    wait_bus_req();
    bus_if.addr_ok = 1'b1;
    step();
    bus_if.addr_ok = 1'b0;
    rst = 1'b1;
    data_if.req = 1'b0;
    step();
    rst = 1'b0;
    bus_if.data_ok = 1'b1;
    bus_if.rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check1("rst_data_inst_data_ok", inst_if.data_ok, 1'b0);
    check1("rst_data_data_data_ok", data_if.data_ok, 1'b0);
    step();
    bus_if.data_ok = 1'b0;
    bus_if.rdata = 32'h0;
    check1("rst_data_idle", bus_if.req, 1'b0);

    // Next tie after that reset goes to data again
    set_inst(1'b1, 1'b0, 2'd2, IADDR, 32'h0);
    set_data(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    push_bus(1'b1, 1'b0, 2'd2, DADDR, 32'h0);
    push_rsp(1'b1, 32'h2222_0001);
    push_bus(1'b0, 1'b0, 2'd2, IADDR, 32'h0);
    push_rsp(1'b0, 32'h2222_0002);
    serve(32'h2222_0001, 1'b0, 1'b1, 0);
    serve(32'h2222_0002, 1'b1, 1'b0, 0);
    repeat (2) step();

    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
